// File: rtl/bytecode_fetch_pkg.sv
// Shared types and constants for the bytecode fetch stage.
// Latency constants count cycles from the opcode read strobe to instr_valid.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatchOp,
    StDecode,
    StArg1W,
    StArg2W,
    StIssue
  } fetch_state_t;

  localparam int unsigned LatNoArg  = 3;
  localparam int unsigned LatOneArg = 5;
  localparam int unsigned LatTwoArg = 7;

  // The decoder can report 3; the fetch stage never collects more than two bytes.
  function automatic logic [1:0] clamp_argc(input logic [1:0] argc);
    return (argc == 2'd3) ? 2'd2 : argc;
  endfunction

endpackage

// File: rtl/bytecode_fetch_if.sv
// Issue channel from the fetch stage to execute: completed instruction plus
// the jump request returned by execute on accept.
interface bytecode_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [7:0]        opcode;
  logic [7:0]        arg1;
  logic [7:0]        arg2;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_en;
  logic [15:0]       jump_offset;

  modport master (
    output opcode, arg1, arg2, instr_pc, instr_valid,
    input  instr_ready, jump_en, jump_offset
  );

  modport slave (
    input  opcode, arg1, arg2, instr_pc, instr_valid,
    output instr_ready, jump_en, jump_offset
  );
endinterface

// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: reads opcode and 0-2 inline argument bytes from synchronous
// program memory, issues the instruction to execute and applies relative jumps.
module bytecode_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  output logic              pmem_rd_o,
  output logic [ADDR_W-1:0] pmem_addr_o,
  input  logic [7:0]        pmem_data_i,
  input  logic [1:0]        argc_i,
  bytecode_fetch_if.master  issue
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        arg1_q, arg1_d;
  logic [7:0]        arg2_q, arg2_d;
  logic              rd_q, rd_d;
  logic              data_vld_q;
  logic [1:0]        argc_n;
  logic [ADDR_W-1:0] offset_ext;

  assign argc_n = clamp_argc(argc_i);

  // Offset is sign-extended for wide pcs and truncated for narrow ones.
  if (ADDR_W <= 16) begin : g_off_trunc
    assign offset_ext = issue.jump_offset[ADDR_W-1:0];
  end else begin : g_off_sext
    assign offset_ext = {{(ADDR_W - 16){issue.jump_offset[15]}}, issue.jump_offset};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    opcode_d   = opcode_q;
    arg1_d     = arg1_q;
    arg2_d     = arg2_q;
    rd_d       = 1'b0;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          rd_d    = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        instr_pc_d = pc_q;
        state_d    = StLatchOp;
      end
      StLatchOp: begin
        opcode_d = pmem_data_i;
        arg1_d   = 8'h00;
        arg2_d   = 8'h00;
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = StDecode;
      end
      StDecode: begin
        if (argc_n == 2'd0) begin
          state_d = StIssue;
        end else begin
          rd_d    = 1'b1;
          state_d = StArg1W;
        end
      end
      // Argument states spend one cycle with the strobe out, then latch the data.
      StArg1W: begin
        if (data_vld_q) begin
          arg1_d = pmem_data_i;
          pc_d   = pc_q + ADDR_W'(1);
          if (argc_n == 2'd1) begin
            state_d = StIssue;
          end else begin
            rd_d    = 1'b1;
            state_d = StArg2W;
          end
        end
      end
      StArg2W: begin
        if (data_vld_q) begin
          arg2_d  = pmem_data_i;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue.instr_ready) begin
          if (issue.jump_en) begin
            pc_d = instr_pc_q + offset_ext;
          end
          if (run_i) begin
            rd_d    = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Every read targets the pc as it stands after this cycle's update.
    if (rd_d) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      addr_q     <= '0;
      opcode_q   <= 8'h00;
      arg1_q     <= 8'h00;
      arg2_q     <= 8'h00;
      rd_q       <= 1'b0;
      data_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      addr_q     <= addr_d;
      opcode_q   <= opcode_d;
      arg1_q     <= arg1_d;
      arg2_q     <= arg2_d;
      rd_q       <= rd_d;
      data_vld_q <= rd_q;
    end
  end

  assign pmem_rd_o         = rd_q;
  assign pmem_addr_o       = addr_q;
  assign issue.opcode      = opcode_q;
  assign issue.arg1        = arg1_q;
  assign issue.arg2        = arg2_q;
  assign issue.instr_pc    = instr_pc_q;
  assign issue.instr_valid = (state_q == StIssue);

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: directed program plus randomized instruction stream,
// with a 16-bit instance and an 8-bit instance for wrap and truncation.
module tb_bytecode_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run, rst8_n, run8;
  logic [7:0] mem [256];
  int         checks = 0;
  int         fails  = 0;
  logic [15:0] exp_pc;

  // 16-bit instance
  bytecode_fetch_if #(.ADDR_W(16)) bus ();
  logic        pmem_rd;
  logic [15:0] pmem_addr;
  logic [7:0]  pmem_data;
  logic [1:0]  argc;

  bytecode_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .pmem_rd_o(pmem_rd), .pmem_addr_o(pmem_addr),
    .pmem_data_i(pmem_data), .argc_i(argc), .issue(bus)
  );

  // 8-bit instance, reset pc at the top of its address space
  bytecode_fetch_if #(.ADDR_W(8)) bus8 ();
  logic       pmem_rd8;
  logic [7:0] pmem_addr8;
  logic [7:0] pmem_data8;
  logic [1:0] argc8;

  bytecode_fetch #(.ADDR_W(8), .RESET_PC(8'hFF)) dut8 (
    .clk(clk), .rst_n(rst8_n), .run_i(run8), .pmem_rd_o(pmem_rd8), .pmem_addr_o(pmem_addr8),
    .pmem_data_i(pmem_data8), .argc_i(argc8), .issue(bus8)
  );

  // Decoder stub: a few named opcodes, otherwise the low two bits.
  function automatic logic [1:0] dec_argc(input logic [7:0] op);
    case (op)
      8'h04:        return 2'd0;
      8'h10, 8'h12: return 2'd1;
      8'h11, 8'ha7: return 2'd2;
      default:      return op[1:0];
    endcase
  endfunction

  assign argc  = dec_argc(bus.opcode);
  assign argc8 = dec_argc(bus8.opcode);

  // Synchronous memory; outside a read the data bus carries noise.
  always @(posedge clk) begin
    if (pmem_rd) pmem_data <= mem[pmem_addr[7:0]];
    else         pmem_data <= 8'($urandom);
    if (pmem_rd8) pmem_data8 <= mem[pmem_addr8];
    else          pmem_data8 <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One instruction through the 16-bit instance, checked against the program model.
  task automatic do_instr(input bit jmp, input logic [15:0] off, input int hold,
                          input bit run_after);
    int t, c, reads, n;
    logic [15:0] ipc, p1, p2;
    logic [7:0]  op, a1, a2;
    run = 1'b1;
    bus.instr_ready = (hold == 0);
    bus.jump_en = jmp;
    bus.jump_offset = off;
    t = 0;
    while (pmem_rd !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("fetch_rd", 32'(pmem_rd), 32'd1);
    chk("fetch_addr", 32'(pmem_addr), 32'(exp_pc));
    ipc = exp_pc;
    p1  = ipc + 16'd1;
    p2  = ipc + 16'd2;
    op  = mem[ipc[7:0]];
    n   = int'(dec_argc(op));
    if (n > 2) n = 2;
    a1 = (n >= 1) ? mem[p1[7:0]] : 8'h00;
    a2 = (n == 2) ? mem[p2[7:0]] : 8'h00;
    c = 0;
    reads = 0;
    while (bus.instr_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
      if (pmem_rd === 1'b1) reads++;
    end
    chk("latency", 32'(c), 32'(3 + 2 * n));
    chk("arg_reads", 32'(reads), 32'(n));
    chk("opcode", 32'(bus.opcode), 32'(op));
    chk("arg1", 32'(bus.arg1), 32'(a1));
    chk("arg2", 32'(bus.arg2), 32'(a2));
    chk("instr_pc", 32'(bus.instr_pc), 32'(ipc));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {6'd0, pmem_rd, bus.instr_valid, bus.opcode, bus.arg1, bus.arg2},
          {6'd0, 1'b0, 1'b1, op, a1, a2});
      chk("hold_pc", 32'(bus.instr_pc), 32'(ipc));
    end
    bus.instr_ready = 1'b1;
    run = run_after;
    @(negedge clk);
    exp_pc = jmp ? (ipc + off) : (ipc + 16'd1 + 16'(n));
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
    if (run_after) begin
      chk("next_rd", 32'(pmem_rd), 32'd1);
      chk("next_addr", 32'(pmem_addr), 32'(exp_pc));
    end else begin
      reads = 0;
      repeat (4) begin
        @(negedge clk);
        if (pmem_rd === 1'b1) reads++;
      end
      chk("idle_no_rd", 32'(reads), 32'd0);
    end
  endtask

  initial begin
    int t, c;
    rst_n = 1'b0;
    rst8_n = 1'b0;
    run = 1'b0;
    run8 = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_offset = 16'h0000;
    bus8.instr_ready = 1'b0;
    bus8.jump_en = 1'b0;
    bus8.jump_offset = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // 0:ICONST_1  1:BIPUSH 7f  3,4:ICONST_1  5:GOTO -3  8:SIPUSH 1234
    mem[0] = 8'h04; mem[1] = 8'h10; mem[2] = 8'h7f; mem[3] = 8'h04; mem[4] = 8'h04;
    mem[5] = 8'ha7; mem[6] = 8'hff; mem[7] = 8'hfd;
    mem[8] = 8'h11; mem[9] = 8'h12; mem[10] = 8'h34;
    repeat (2) @(negedge clk);
    chk("rst_outs", {15'd0, pmem_rd, pmem_addr}, 32'd0);
    chk("rst_issue", {bus.instr_valid, bus.opcode, bus.arg1, bus.arg2}, 32'd0);
    chk("rst_ipc", 32'(bus.instr_pc), 32'd0);
    rst_n = 1'b1;
    exp_pc = 16'h0000;

    do_instr(1'b0, 16'h0000, 0, 1'b1);
    do_instr(1'b0, 16'h0000, 0, 1'b1);
    do_instr(1'b0, 16'h0000, 0, 1'b1);
    do_instr(1'b0, 16'h0000, 0, 1'b1);
    do_instr(1'b1, 16'hfffd, 0, 1'b1);    // GOTO back to 2
    do_instr(1'b0, 16'h1234, 5, 1'b0);    // opcode 7f reports argc 3
    do_instr(1'b0, 16'h0000, 0, 1'b1);    // GOTO at 5 not taken

    // Reset while the first argument read of SIPUSH is outstanding.
    run = 1'b1;
    t = 0;
    while (pmem_rd !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("sipush_addr", 32'(pmem_addr), 32'd8);
    repeat (3) @(negedge clk);
    chk("arg1_rd", 32'(pmem_rd), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {15'd0, pmem_rd, pmem_addr}, 32'd0);
    chk("mid_rst_issue", {bus.instr_valid, bus.opcode, bus.arg1, bus.arg2}, 32'd0);
    @(negedge clk);
    chk("mid_rst_ipc", 32'(bus.instr_pc), 32'd0);
    rst_n = 1'b1;
    exp_pc = 16'h0000;
    do_instr(1'b0, 16'h0000, 0, 1'b1);

    // Random program and control.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      do_instr(($urandom_range(0, 3) == 0), 16'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 4) != 0));
    end
    run = 1'b0;

    // 8-bit instance: pc wrap at 0xFF, offset truncation, run=0 at accept.
    mem[8'hff] = 8'h04; mem[8'h00] = 8'h04; mem[8'h05] = 8'h04;
    @(negedge clk);
    chk("rst8_outs", {15'd0, pmem_rd8, 8'h00, pmem_addr8}, 32'd0);
    bus8.instr_ready = 1'b1;
    run8 = 1'b1;
    rst8_n = 1'b1;
    t = 0;
    while (pmem_rd8 !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("w8_addr", 32'(pmem_addr8), 32'h0ff);
    c = 0;
    while (bus8.instr_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("w8_latency", 32'(c), 32'(LatNoArg));
    chk("w8_opcode", 32'(bus8.opcode), 32'h04);
    chk("w8_ipc", 32'(bus8.instr_pc), 32'h0ff);
    @(negedge clk);
    chk("w8_wrap_rd", 32'(pmem_rd8), 32'd1);
    chk("w8_wrap_addr", 32'(pmem_addr8), 32'h000);
    c = 0;
    while (bus8.instr_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("w8_ipc0", 32'(bus8.instr_pc), 32'h000);
    bus8.jump_en = 1'b1;
    bus8.jump_offset = 16'h0105;
    run8 = 1'b0;
    @(negedge clk);
    chk("w8_valid_drop", 32'(bus8.instr_valid), 32'd0);
    c = 0;
    repeat (4) begin
      @(negedge clk);
      if (pmem_rd8 === 1'b1) c++;
    end
    chk("w8_idle_no_rd", 32'(c), 32'd0);
    run8 = 1'b1;
    t = 0;
    while (pmem_rd8 !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("w8_resume_rd", 32'(pmem_rd8), 32'd1);
    chk("w8_jump_addr", 32'(pmem_addr8), 32'h005);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
